// File: rtl/nmr_voter.sv
// -----------------------------------------------------------------------------
// nmr_voter
//
// Clocked N-modular-redundancy voter with self-healing fault exclusion.
// Sits between N replicated datapath units and their single consumer.
// Each cycle it forms a bitwise majority (word and status flag) over the
// replicas that are still healthy and registers the result.
//
// A leaky counter per replica tracks disagreement with the vote. A replica
// whose counter reaches THRESH is permanently dropped from the vote, unless
// dropping it (together with any same-edge exclusions) would leave nobody
// voting. In that case the exclusion is suppressed and the sticky fatal flag
// is raised instead.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   valid_in     a sample is present this cycle
//   data_in      N replica words, replica i at [i*WIDTH +: WIDTH]
//   flag_in      N replica status flags, replica i at bit i
//   clear_mask   restore all replicas to healthy, clear counters and fatal
//   valid_out    registered valid_in
//   data_out     voted word (holds while valid_out=0)
//   flag_out     voted flag (holds while valid_out=0)
//   split        voted sample had a tie on at least one bit or on the flag
//   health_mask  1 = replica participates in the vote
//   fault_pulse  one-cycle pulse for each replica excluded at the last edge
//   fatal        sticky: an exclusion was suppressed to keep H > 0
// -----------------------------------------------------------------------------
module nmr_voter #(
    parameter int WIDTH  = 32,
    parameter int N      = 5,
    parameter int THRESH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [N-1:0]       flag_in,
    input  logic               clear_mask,
    output logic               valid_out,
    output logic [WIDTH-1:0]   data_out,
    output logic               flag_out,
    output logic               split,
    output logic [N-1:0]       health_mask,
    output logic [N-1:0]       fault_pulse,
    output logic               fatal
);

    localparam int CW = $clog2(THRESH + 1);  // leaky counter width
    localparam int PW = $clog2(N + 1);       // popcount / ones width
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    // Registered state
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             flag_q;
    logic             split_q;
    logic [N-1:0]     health_q, health_d;
    logic [N-1:0]     fault_q,  fault_d;
    logic             fatal_q,  fatal_d;
    logic [CW-1:0]    cnt_q [N];
    logic [CW-1:0]    cnt_d [N];

    // Combinational vote
    logic [PW-1:0]    h_cnt;
    logic [WIDTH-1:0] low_word;
    logic             low_flag;
    logic [WIDTH-1:0] vote_word;
    logic             vote_flag;
    logic             vote_split;
    logic [N-1:0]     col;
    logic [1:0]       vr;

    // Counter / exclusion bookkeeping
    logic             accept;
    logic [N-1:0]     disagree;
    logic [N-1:0]     excl;
    logic             suppress;

    // Majority of one bit column over the healthy replicas.
    // Returns {tie, value}; on a tie the lowest-index healthy replica wins.
    // The ones count is doubled into PW+1 bits so 2*ones never truncates.
    function automatic logic [1:0] vote_bit(
        input logic [N-1:0]  bits,
        input logic [N-1:0]  mask,
        input logic [PW-1:0] h,
        input logic          low_bit
    );
        logic [PW-1:0] ones;
        logic [PW:0]   twice_ones;
        logic [PW:0]   h_ext;
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + PW'(bits[i] & mask[i]);
        end
        twice_ones = {ones, 1'b0};
        h_ext      = {1'b0, h};
        if (twice_ones > h_ext)      return 2'b01;
        else if (twice_ones < h_ext) return 2'b00;
        else                         return {1'b1, low_bit};
    endfunction

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        h_cnt      = '0;
        low_word   = '0;
        low_flag   = 1'b0;
        vote_word  = '0;
        vote_flag  = 1'b0;
        vote_split = 1'b0;
        col        = '0;
        vr         = '0;

        for (int i = 0; i < N; i++) begin
            h_cnt = h_cnt + PW'(health_q[i]);
        end

        // Scan downwards so the lowest-index healthy replica is the last write.
        for (int i = N - 1; i >= 0; i--) begin
            if (health_q[i]) begin
                low_word = data_in[i*WIDTH +: WIDTH];
                low_flag = flag_in[i];
            end
        end

        for (int b = 0; b < WIDTH; b++) begin
            for (int i = 0; i < N; i++) begin
                col[i] = data_in[i*WIDTH + b];
            end
            vr           = vote_bit(col, health_q, h_cnt, low_word[b]);
            vote_word[b] = vr[0];
            vote_split   = vote_split | vr[1];
        end

        vr         = vote_bit(flag_in, health_q, h_cnt, low_flag);
        vote_flag  = vr[0];
        vote_split = vote_split | vr[1];
    end

    always_comb begin
        accept   = valid_in && !vote_split;
        disagree = '0;
        excl     = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        // Excluded replicas are ignored: their counters freeze at THRESH.
        for (int i = 0; i < N; i++) begin
            disagree[i] = (data_in[i*WIDTH +: WIDTH] != vote_word) ||
                          (flag_in[i] != vote_flag);
            if (accept && health_q[i]) begin
                if (disagree[i]) begin
                    cnt_d[i] = (cnt_q[i] == THRESH_C) ? cnt_q[i] : cnt_q[i] + 1'b1;
                end else begin
                    cnt_d[i] = (cnt_q[i] == '0) ? cnt_q[i] : cnt_q[i] - 1'b1;
                end
                excl[i] = (cnt_d[i] == THRESH_C);
            end
        end

        // Same-edge exclusions apply as a set or not at all.
        suppress = (|excl) && ((health_q & ~excl) == '0);
        health_d = suppress ? health_q : (health_q & ~excl);
        fault_d  = suppress ? '0 : excl;
        fatal_d  = fatal_q | suppress;

        // clear_mask wins over any update from the same edge; the sample of
        // this cycle has already been voted with the old mask.
        if (clear_mask) begin
            health_d = '1;
            fault_d  = '0;
            fatal_d  = 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            flag_q   <= 1'b0;
            split_q  <= 1'b0;
            health_q <= '1;
            fault_q  <= '0;
            fatal_q  <= 1'b0;
            // NOTE: the counter array is a handful of flops, not a RAM, and
            // its reset value is architecturally visible, so it is reset here.
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                data_q  <= vote_word;
                flag_q  <= vote_flag;
                split_q <= vote_split;
            end
            health_q <= health_d;
            fault_q  <= fault_d;
            fatal_q  <= fatal_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign valid_out   = valid_q;
    assign data_out    = data_q;
    assign flag_out    = flag_q;
    assign split       = split_q;
    assign health_mask = health_q;
    assign fault_pulse = fault_q;
    assign fatal       = fatal_q;

endmodule

// File: tb/tb_nmr_voter.sv
// -----------------------------------------------------------------------------
// tb_nmr_voter
//
// Directed bench for nmr_voter with N=5, WIDTH=8, THRESH=3. Each vector is
// applied on the falling edge; outputs are sampled 1 time unit after the
// following rising edge and compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_nmr_voter;

    localparam int WIDTH  = 8;
    localparam int N      = 5;
    localparam int THRESH = 3;

    logic               clk;
    logic               reset;
    logic               valid_in;
    logic [N*WIDTH-1:0] data_in;
    logic [N-1:0]       flag_in;
    logic               clear_mask;
    logic               valid_out;
    logic [WIDTH-1:0]   data_out;
    logic               flag_out;
    logic               split;
    logic [N-1:0]       health_mask;
    logic [N-1:0]       fault_pulse;
    logic               fatal;

    int checks = 0;
    int errors = 0;

    nmr_voter #(
        .WIDTH  (WIDTH),
        .N      (N),
        .THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .flag_in     (flag_in),
        .clear_mask  (clear_mask),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .flag_out    (flag_out),
        .split       (split),
        .health_mask (health_mask),
        .fault_pulse (fault_pulse),
        .fatal       (fatal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and return just after the capturing edge.
    task automatic send(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input logic [7:0] w3, input logic [7:0] w4,
                        input logic [4:0] f, input logic v, input logic clr);
        @(negedge clk);
        data_in    = {w4, w3, w2, w1, w0};
        flag_in    = f;
        valid_in   = v;
        clear_mask = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic f, input logic s, input logic [4:0] hm,
                             input logic [4:0] fp, input logic ft);
        check({tag, ".valid"},  32'(valid_out),   32'(v));
        check({tag, ".data"},   32'(data_out),    32'(d));
        check({tag, ".flag"},   32'(flag_out),    32'(f));
        check({tag, ".split"},  32'(split),       32'(s));
        check({tag, ".health"}, 32'(health_mask), 32'(hm));
        check({tag, ".fault"},  32'(fault_pulse), 32'(fp));
        check({tag, ".fatal"},  32'(fatal),       32'(ft));
    endtask

    initial begin
        reset      = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        flag_in    = '0;
        clear_mask = 1'b0;

        // Reset state, held across edges.
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Unanimous sample, one-cycle latency.
        send(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 5'b00000, 1'b1, 1'b0);
        check_out("unanimous", 1'b1, 8'hA5, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);

        // Idle cycle: valid drops, voted values hold.
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00000, 1'b0, 1'b0);
        check_out("idle_hold", 1'b0, 8'hA5, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);

        // Flag majority 3 of 5 -> 1 (cnt3=cnt4=1), then all agree (back to 0).
        send(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 5'b00111, 1'b1, 1'b0);
        check_out("flag_maj", 1'b1, 8'hA5, 1'b1, 1'b0, 5'b11111, 5'b00000, 1'b0);
        send(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 5'b00000, 1'b1, 1'b0);
        check_out("flag_agree", 1'b1, 8'hA5, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);

        // Replica 2 glitches once (cnt2 1) then agrees (cnt2 0).
        send(8'h3C, 8'h3C, 8'h00, 8'h3C, 8'h3C, 5'b00000, 1'b1, 1'b0);
        check_out("r2_glitch", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        send(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 5'b00000, 1'b1, 1'b0);
        check_out("r2_agree", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        // Two more disagreements reach only cnt2=2 if the leak worked.
        send(8'h3C, 8'h3C, 8'h00, 8'h3C, 8'h3C, 5'b00000, 1'b1, 1'b0);
        send(8'h3C, 8'h3C, 8'h00, 8'h3C, 8'h3C, 5'b00000, 1'b1, 1'b0);
        check_out("r2_leak", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        send(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 5'b00000, 1'b1, 1'b0);
        send(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 5'b00000, 1'b1, 1'b0);

        // Replica 4 stuck at FF for three samples -> excluded on the third.
        send(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("r4_s1", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        send(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("r4_s2", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        send(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("r4_excl", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b01111, 5'b10000, 1'b0);
        send(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("r4_after", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b01111, 5'b00000, 1'b0);

        // H=4 tie: 11,11,22,22 -> lowest healthy (r0) wins, split set.
        // Five split samples; any counter motion would exclude r2/r3.
        for (int k = 0; k < 5; k++) begin
            send(8'h11, 8'h11, 8'h22, 8'h22, 8'hFF, 5'b00000, 1'b1, 1'b0);
            check_out($sformatf("tie%0d", k), 1'b1, 8'h11, 1'b0, 1'b1, 5'b01111, 5'b00000, 1'b0);
        end

        // Exclude replica 3 to reach H=3 over replicas 0..2.
        for (int k = 0; k < 3; k++) begin
            send(8'h3C, 8'h3C, 8'h3C, 8'h00, 8'hFF, 5'b00000, 1'b1, 1'b0);
        end
        check_out("r3_excl", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0);

        // Each of r0..r2 flips a different bit: vote stays 3C, all disagree.
        send(8'h3D, 8'h3E, 8'h38, 8'h00, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("multi1", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b00111, 5'b00000, 1'b0);
        send(8'h3D, 8'h3E, 8'h38, 8'h00, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("multi2", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b00111, 5'b00000, 1'b0);
        send(8'h3D, 8'h3E, 8'h38, 8'h00, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("fatal_set", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b00111, 5'b00000, 1'b1);
        // Saturated counters: suppression repeats, fatal stays sticky.
        send(8'h3D, 8'h3E, 8'h38, 8'h00, 8'hFF, 5'b00000, 1'b1, 1'b0);
        check_out("fatal_hold", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b00111, 5'b00000, 1'b1);

        // clear_mask with a valid sample: voted with old mask (r0..r2 = 3C,
        // r3/r4 ignored), then mask restored and fatal cleared.
        send(8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00, 5'b11000, 1'b1, 1'b1);
        check_out("clear", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        // Counters were zeroed: one disagreement by r0 must not exclude it.
        send(8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 5'b00000, 1'b1, 1'b0);
        check_out("post_clear", 1'b1, 8'h3C, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);

        // Mid-stream reset between two valid samples.
        send(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 5'b00000, 1'b1, 1'b0);
        check_out("pre_reset", 1'b1, 8'h5A, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        @(negedge clk);
        data_in  = {5{8'h77}};
        valid_in = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_held", 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        send(8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 5'b11111, 1'b1, 1'b0);
        check_out("post_reset", 1'b1, 8'h66, 1'b1, 1'b0, 5'b11111, 5'b00000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmr_voter.md
# nmr_voter

Parametrised N-modular-redundancy voter with self-healing fault exclusion, the clocked successor to the fixed 10-way combinational replica vote. It sits between N replicated datapath units (ALU, adder, register read ports) and their single consumer. It takes N result words plus N status flags per sample and produces a registered bitwise-majority result. It tracks per-replica disagreement with a leaky counter and permanently excludes a replica from voting once its count reaches a threshold.

## Interface
- WIDTH, 32, data word width per replica
- N, 5, replica count (N ≥ 3)
- THRESH, 3, leaky-counter value at which a replica is excluded (1..15)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  sample present this cycle
- data_in  in  N*WIDTH  replica words, replica i at [i*WIDTH +: WIDTH]
- flag_in  in  N  replica status flag (e.g. zero), replica i at bit i
- clear_mask  in  1  restore all replicas to healthy, clear counters and fatal
- valid_out  out  1  registered valid_in
- data_out  out  WIDTH  voted word
- flag_out  out  1  voted flag
- split  out  1  voted sample had a tie on at least one bit or the flag
- health_mask  out  N  1 = replica participates in vote
- fault_pulse  out  N  one-cycle pulse when replica i becomes excluded
- fatal  out  1  sticky; an exclusion was suppressed because it would leave zero healthy replicas

## Operation
- Vote is combinational over the current health_mask, then registered. H = popcount(health_mask). Per bit (and for the flag), ones = count of healthy replicas driving 1.
  - 2*ones > H gives 1. 2*ones < H gives 0.
  - 2*ones == H is a tie: take the bit from the lowest-index healthy replica and set split.
- A healthy replica disagrees if its word or its flag differs from the voted word or flag in any bit. Excluded replicas are ignored entirely, and their counters freeze.
- Counter update on an accepted sample (valid_in=1, split=0):
  - Disagree: cnt+1, saturating at THRESH.
  - Agree: cnt−1, floor 0.
- On split samples and valid_in=0 cycles, counters and mask are unchanged.
- Exclusion: a replica whose updated cnt equals THRESH gets its health_mask bit cleared and its fault_pulse bit pulsed.
  - Multiple replicas may be excluded on the same edge.
  - If the set of same-edge exclusions would make H=0, none of them applies. Counters still update, fatal sets, and no fault_pulse fires.
- Exclusion is permanent until reset or clear_mask.
- clear_mask at an edge:
  - health_mask goes to all ones, all counters to 0, fatal to 0, fault_pulse to 0.
  - It overrides any counter or mask update from the same edge.
  - The sample voted in that cycle still uses the old mask and is output normally.
- Counter width is ceil(log2(THRESH+1)). Popcount and ones counters are ceil(log2(N+1)) bits, and comparisons use 2*ones against H without truncation.

## Timing
- Reset (reset=0, async) sets:
  - valid_out, data_out, flag_out, split, fault_pulse, fatal to 0.
  - health_mask to all ones.
  - counters to 0.
- Outputs hold their reset values while reset is low. Asserting reset mid-stream discards the in-flight sample. The first valid_out follows the first rising edge after reset deasserts with valid_in=1.
- Latency is 1 cycle. A sample on valid_in at edge k appears on valid_out/data_out/flag_out/split after edge k. Throughput is one sample per cycle, with no backpressure.
- The vote of sample k uses health_mask before edge k. A mask change from sample k first affects sample k+1.
- When valid_out=0, data_out, flag_out and split hold their last values.
- fault_pulse is high for exactly the cycle after the excluding edge.

## Test plan
- Reset with N=5, WIDTH=8, THRESH=3 → all outputs 0 and health_mask=5'b11111. Release, drive all replicas 8'hA5 with flag 0 → data_out=8'hA5 and valid_out=1 one cycle later, split=0.
- Replica 2 drives 8'h00 for one sample, then 8'h3C with the others at 8'h3C → data_out 8'h3C both cycles. Counter2 goes 1 then 0, and no exclusion occurs.
- Replica 4 stuck at 8'hFF for 3 consecutive samples, others 8'h3C → data_out=8'h3C throughout. health_mask=5'b01111 after the third sample, fault_pulse=5'b10000 for one cycle.
- With replica 4 excluded (H=4): replicas 0,1 drive 8'h11 and replicas 2,3 drive 8'h22 → split=1, data_out=8'h11, counters unchanged over 5 such samples.
- Each of replicas 0..2 (H=3) corrupts a different bit for 3 samples → data_out stays correct, fatal=1, health_mask unchanged, fault_pulse stays 0. A clear_mask pulse then drives fatal to 0 and health_mask to 5'b11111.
- Assert reset for 1 cycle between two valid samples → outputs drop to 0 immediately, and the second sample emerges normally after release.
